// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential BCD-to-binary converter.
package bcd_pkg;

  // Width of one packed BCD digit.
  localparam int BCD_DIGIT_W = 4;

  // Largest legal decimal digit value.
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // Reverse double dabble correction: a digit that reaches 8 or more after a
  // right shift has received a carried-in 10 (seen as 8), so 3 is removed to
  // turn it back into 5 (half of 10).
  localparam logic [3:0] DABBLE_THRESH = 4'd8;
  localparam logic [3:0] DABBLE_ADJ    = 4'd3;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_conv_state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_sub3.sv
// Per-digit reverse double dabble correction: subtract 3 when the digit is >= 8.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Purely combinational correction applied to a freshly shifted digit.
  assign digit_o = (digit_i >= DABBLE_THRESH) ? (digit_i - DABBLE_ADJ) : digit_i;

endmodule : bcd_digit_sub3

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble.
// One right shift plus per-digit correction per clock; valid/ready on both
// sides; illegal input digits (> 9) short-circuit to an error result.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 21
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcds_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bNum_out,
  output logic                          bcd_err
);

  // Number of shifts needed to move every decimal value below 10**DIGITS
  // completely into the binary field.
  localparam int N_SHIFT = $clog2(10 ** DIGITS);
  localparam int BCD_W   = BCD_DIGIT_W * DIGITS;
  localparam int SR_W    = BCD_W + N_SHIFT;
  localparam int CNT_W   = $clog2(N_SHIFT + 1);

  // The result port must be able to hold the full binary field.
  if (BIN_W < N_SHIFT) begin : g_width_check
    $error("bcd_to_binary_seq: BIN_W must be >= N_SHIFT");
  end

  bcd_conv_state_t  state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bnum_q, bnum_d;
  logic             err_q, err_d;

  // Datapath for one shift step: shift the whole register right, then
  // correct each digit of the bcd field.
  logic [SR_W-1:0]    sr_shift;
  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_adj;
  logic [N_SHIFT-1:0] bin_shift;

  assign sr_shift  = sr_q >> 1;
  assign bcd_shift = sr_shift[SR_W-1:N_SHIFT];
  assign bin_shift = sr_shift[N_SHIFT-1:0];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dabble
    bcd_digit_sub3 u_sub3 (
      .digit_i (bcd_shift[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Range check of the incoming digits; only consulted at accept time.
  logic [DIGITS-1:0] digit_bad;
  logic              any_bad;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_range
    assign digit_bad[gi] = (bcds_in[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_MAX);
  end

  assign any_bad = |digit_bad;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bnum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bnum_q  <= bnum_d;
      err_q   <= err_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    bnum_d    = bnum_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (any_bad) begin
            // Illegal digit: no conversion, report the error next cycle.
            err_d   = 1'b1;
            bnum_d  = '0;
            state_d = DONE;
          end else begin
            sr_d    = {bcds_in, {N_SHIFT{1'b0}}};
            cnt_d   = CNT_W'(N_SHIFT);
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        sr_d  = {bcd_adj, bin_shift};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last shift: capture the binary field straight from the shifter.
          bnum_d  = BIN_W'(bin_shift);
          err_d   = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bNum_out = bnum_q;
  assign bcd_err  = err_q;

  // Once the last shift is taken, every decimal digit must have drained
  // into the binary field; anything left means the shift count is wrong.
  always_ff @(posedge clk) begin
    if (!reset && state_q == SHIFT && cnt_q == CNT_W'(1)) begin
      assert (bcd_adj == '0);
    end
  end

endmodule : bcd_to_binary_seq

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq (default parameters).
module tb_bcd_to_binary_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] bcds_in;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] bNum_out;
  logic        bcd_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq #(
    .DIGITS (6),
    .BIN_W  (21)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcds_in   (bcds_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bNum_out  (bNum_out),
    .bcd_err   (bcd_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal value of a packed 6-digit BCD word.
  function automatic int bcd_value(input logic [23:0] v);
    int r = 0;
    for (int k = 5; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  // Binary to packed BCD by repeated division.
  function automatic logic [23:0] to_bcd(input int b);
    logic [23:0] r;
    int t = b;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Present one word and let the accepting edge pass.
  task automatic send(input logic [23:0] v);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    bcds_in  = v;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid is seen (bounded).
  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  // Consume the result and confirm the return to IDLE.
  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("take_in_ready", 32'(in_ready), 32'd1);
    check("take_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Full legal conversion with latency, value and error-flag checks.
  task automatic convert(input string tag, input logic [23:0] v, input int exp_val);
    int lat;
    send(v);
    wait_out(0, lat);
    check({tag, "_latency"}, 32'(lat), 32'd20);
    check({tag, "_value"}, 32'(bNum_out), 32'(exp_val));
    check({tag, "_err"}, 32'(bcd_err), 32'd0);
    $display("conv %s: bcd=%06h bin=%0d latency=%0d", tag, v, bNum_out, lat);
    take();
  endtask

  // Illegal-digit input: result must appear right after the accepting edge.
  task automatic convert_bad(input string tag, input logic [23:0] v);
    int lat;
    send(v);
    wait_out(0, lat);
    check({tag, "_latency"}, 32'(lat), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_err"}, 32'(bcd_err), 32'd1);
    check({tag, "_value"}, 32'(bNum_out), 32'd0);
    $display("conv %s: bcd=%06h err=%0d bin=%0d", tag, v, bcd_err, bNum_out);
    take();
  endtask

  initial begin
    int lat;
    logic [23:0] rb;
    int rv;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcds_in   = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_bnum", 32'(bNum_out), 32'd0);
    check("reset_err", 32'(bcd_err), 32'd0);
    $display("reset: in_ready=%0d out_valid=%0d bNum_out=%0d", in_ready, out_valid, bNum_out);

    // Basic values
    convert("zero", 24'h000000, 0);
    convert("all9", 24'h999999, 999999);
    convert("mixed", 24'h123456, 123456);

    // Illegal digits, least and most significant positions
    convert_bad("bad_lsd", 24'h00000A);
    convert_bad("bad_msd", 24'hF00000);

    // Backpressure: result held, input ignored
    send(24'h000255);
    check("bp_shift_in_ready", 32'(in_ready), 32'd0);
    wait_out(0, lat);
    check("bp_latency", 32'(lat), 32'd20);
    in_valid = 1'b1;
    bcds_in  = 24'h000999;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_value", 32'(bNum_out), 32'd255);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    $display("backpressure: held bin=%0d for 5 cycles", bNum_out);
    take();

    // Input during SHIFT is dropped
    send(24'h000042);
    repeat (4) tick();
    in_valid = 1'b1;
    bcds_in  = 24'h000777;
    tick();
    in_valid = 1'b0;
    wait_out(5, lat);
    check("drop_latency", 32'(lat), 32'd20);
    check("drop_value", 32'(bNum_out), 32'd42);
    $display("drop: bin=%0d latency=%0d", bNum_out, lat);
    take();
    repeat (3) tick();
    check("drop_no_second_valid", 32'(out_valid), 32'd0);
    check("drop_idle", 32'(in_ready), 32'd1);

    // Reset mid-conversion
    send(24'h000500);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_bnum", 32'(bNum_out), 32'd0);
    check("midrst_err", 32'(bcd_err), 32'd0);
    $display("midreset: in_ready=%0d out_valid=%0d bNum_out=%0d", in_ready, out_valid, bNum_out);
    reset = 1'b0;
    tick();
    check("after_rst_out_valid", 32'(out_valid), 32'd0);
    convert("after_rst", 24'h000100, 100);

    // Round trip: random binary -> BCD -> DUT -> binary
    for (int i = 0; i < 8; i++) begin
      rv = int'($urandom_range(999999, 0));
      rb = to_bcd(rv);
      check("rt_model", 32'(bcd_value(rb)), 32'(rv));
      convert("roundtrip", rb, rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bcd_to_binary_seq
